// File: rtl/mux_2_1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_2_1
//  Description : Packet-aware 2:1 stream multiplexer. A multi-beat packet
//                locks the selected source until its last beat is accepted.
//                The output is decoupled by a 2-entry skid FIFO that holds
//                data and last together, so the slave readies never depend
//                combinationally on m_ready.
//                Optional macro MUX_PKT_CNT_EN adds the 16-bit per-source
//                packet counters pkt_cnt_1 / pkt_cnt_2.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_2_1 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic [DATA_W-1:0] s_data_1,
    input  logic              s_valid_1,
    input  logic              s_last_1,
    output logic              s_ready_1,
    input  logic [DATA_W-1:0] s_data_2,
    input  logic              s_valid_2,
    input  logic              s_last_2,
    output logic              s_ready_2,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
`ifdef MUX_PKT_CNT_EN
    ,
    output logic [15:0]       pkt_cnt_1,
    output logic [15:0]       pkt_cnt_2
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_1 = 2'd1,
        LOCK_2 = 2'd2
    } state_t;

    state_t            state_q;
    logic              rst_done_q;   // one cycle after reset release before accepting
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [DATA_W:0]   mem_q [2];    // {last, data}

    logic              act_2;        // 1 when slave 2 is the active input
    logic              space_ok;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic              push_last;
    logic [DATA_W:0]   head;

    // Active source selection and handshake decode
    always_comb begin
        act_2     = (state_q == LOCK_2) || ((state_q == IDLE) && sel);
        // Space is judged from registered occupancy only, never from m_ready
        space_ok  = rst_done_q && (count_q != 2'd2);
        s_ready_1 = space_ok && !act_2;
        s_ready_2 = space_ok && act_2;
        push      = act_2 ? (s_valid_2 && s_ready_2) : (s_valid_1 && s_ready_1);
        push_data = act_2 ? s_data_2 : s_data_1;
        push_last = act_2 ? s_last_2 : s_last_1;
        head      = mem_q[rd_ptr_q];
        m_valid   = (count_q != 2'd0);
        m_data    = head[DATA_W-1:0];
        m_last    = head[DATA_W];
        pop       = m_valid && m_ready;
    end

    // Next occupancy: a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Lock state machine: multi-beat packets hold the source until last
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push && !push_last)
                        state_q <= act_2 ? LOCK_2 : LOCK_1;
                end
                LOCK_1, LOCK_2: begin
                    if (push && push_last)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Acceptance is held off for the first edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
        end
    end

    // Two-entry output FIFO; storage is cleared so outputs read zero in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {push_last, push_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

`ifdef MUX_PKT_CNT_EN
    logic [15:0] pkt_cnt_1_q;
    logic [15:0] pkt_cnt_2_q;

    // Count accepted end-of-packet beats per source, wrapping naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt_1_q <= 16'd0;
            pkt_cnt_2_q <= 16'd0;
        end else if (push && push_last) begin
            if (act_2)
                pkt_cnt_2_q <= pkt_cnt_2_q + 16'd1;
            else
                pkt_cnt_1_q <= pkt_cnt_1_q + 16'd1;
        end
    end

    assign pkt_cnt_1 = pkt_cnt_1_q;
    assign pkt_cnt_2 = pkt_cnt_2_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_2_1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_2_1
//  Description : Scoreboard bench for mux_2_1. A packet-level reference
//                (current owner of the output, beats in flight) predicts
//                readies and the accepted beats; a monitor pops expected
//                beats whenever the master side transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_2_1;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              sel = 1'b0;
    logic [DATA_W-1:0] s_data_1 = '0;
    logic              s_valid_1 = 1'b0;
    logic              s_last_1 = 1'b0;
    logic              s_ready_1;
    logic [DATA_W-1:0] s_data_2 = '0;
    logic              s_valid_2 = 1'b0;
    logic              s_last_2 = 1'b0;
    logic              s_ready_2;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready = 1'b0;
`ifdef MUX_PKT_CNT_EN
    logic [15:0]       pkt_cnt_1;
    logic [15:0]       pkt_cnt_2;
`endif

    mux_2_1 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .s_data_1  (s_data_1),
        .s_valid_1 (s_valid_1),
        .s_last_1  (s_last_1),
        .s_ready_1 (s_ready_1),
        .s_data_2  (s_data_2),
        .s_valid_2 (s_valid_2),
        .s_last_2  (s_last_2),
        .s_ready_2 (s_ready_2),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready)
`ifdef MUX_PKT_CNT_EN
        ,
        .pkt_cnt_1 (pkt_cnt_1),
        .pkt_cnt_2 (pkt_cnt_2)
`endif
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [DATA_W:0] exp_q [$];      // beats accepted, not yet delivered: {last, data}
    int              owner    = 0;   // 0 = no packet in progress, else source 1/2
    int              rst_seen = 0;   // rising edges seen since reset release
    logic            pend_v   = 1'b0;
    int              pend_src = 0;
    logic [DATA_W:0] pend_b   = '0;
    int              mcnt1    = 0;
    int              mcnt2    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the reference prediction for the next edge
    task automatic cycle(input logic s, input logic v1, input logic [DATA_W-1:0] d1, input logic l1,
                         input logic v2, input logic [DATA_W-1:0] d2, input logic l2, input logic mr);
        logic space;
        int   act;
        logic av;
        logic al;
        logic [DATA_W-1:0] ad;
        @(posedge clk);
        #1;
        if (pend_v) begin
            exp_q.push_back(pend_b);
            if (pend_b[DATA_W]) begin
                if (pend_src == 1) mcnt1 = (mcnt1 + 1) % 65536;
                else               mcnt2 = (mcnt2 + 1) % 65536;
            end
            pend_v = 1'b0;
        end
        if (reset && rst_seen < 2) rst_seen++;
        sel = s; s_valid_1 = v1; s_data_1 = d1; s_last_1 = l1;
        s_valid_2 = v2; s_data_2 = d2; s_last_2 = l2; m_ready = mr;
        #1;
        space = (rst_seen >= 1) && (exp_q.size() < 2);
        act   = (owner != 0) ? owner : (s ? 2 : 1);
        check("s_ready_1", {31'd0, s_ready_1}, {31'd0, space && (act == 1)});
        check("s_ready_2", {31'd0, s_ready_2}, {31'd0, space && (act == 2)});
        av = (act == 1) ? v1 : v2;
        ad = (act == 1) ? d1 : d2;
        al = (act == 1) ? l1 : l2;
        if (space && av) begin
            pend_v   = 1'b1;
            pend_src = act;
            pend_b   = {al, ad};
            owner    = al ? 0 : act;
        end
    endtask

    // Asynchronous reset asserted and released between clock edges
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        s_valid_1 = 1'b0;
        s_valid_2 = 1'b0;
        #1;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_m_last", {31'd0, m_last}, 32'd0);
        check("rst_s_ready_1", {31'd0, s_ready_1}, 32'd0);
        check("rst_s_ready_2", {31'd0, s_ready_2}, 32'd0);
        exp_q.delete();
        pend_v = 1'b0; owner = 0; rst_seen = 0; mcnt1 = 0; mcnt2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: compares every master-side transfer with the expected head beat
    initial begin
        logic [DATA_W:0] b;
        forever begin
            @(negedge clk);
            check("m_valid", {31'd0, m_valid}, {31'd0, exp_q.size() != 0});
            if (m_valid && m_ready && exp_q.size() != 0) begin
                b = exp_q.pop_front();
                check("m_data", {24'd0, m_data}, {24'd0, b[DATA_W-1:0]});
                check("m_last", {31'd0, m_last}, {31'd0, b[DATA_W]});
            end
`ifdef MUX_PKT_CNT_EN
            check("pkt_cnt_1", {16'd0, pkt_cnt_1}, mcnt1);
            check("pkt_cnt_2", {16'd0, pkt_cnt_2}, mcnt2);
`endif
        end
    end

    initial begin
        #3;
        check("init_m_valid", {31'd0, m_valid}, 32'd0);
        check("init_s_ready_1", {31'd0, s_ready_1}, 32'd0);
        check("init_s_ready_2", {31'd0, s_ready_2}, 32'd0);
        #19;
        reset = 1'b1;

        // Pass-through from slave 1, packet left open
        repeat (4) cycle(1'b0, 1'b1, 8'h23, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        // sel flips mid-packet: slave 1 keeps the output until its last beat
        repeat (3) cycle(1'b1, 1'b1, 8'h23, 1'b0, 1'b1, 8'h45, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 8'h24, 1'b1, 1'b1, 8'h45, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h45, 1'b0, 1'b1);
        // Back-pressure on a locked slave-2 packet, then release
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        check("bp_fifo_full", {31'd0, m_valid}, 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h60 + 8'(i), 1'b1, 1'b1);
        // Single-beat packets with sel toggling every cycle
        for (int i = 0; i < 12; i++)
            cycle(1'(i), 1'b1, 8'h10 + 8'(i), 1'b1, 1'b1, 8'h90 + 8'(i), 1'b1, 1'b1);
        // Reset while slave 2 holds the lock with two beats buffered
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        do_reset();
        repeat (4) cycle(1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 8'h82, 1'b1, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) do_reset();
            cycle(1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(3) == 0,
                  1'($urandom), 8'($urandom), $urandom_range(3) == 0, $urandom_range(3) != 0);
        end

`ifdef MUX_PKT_CNT_EN
        do_reset();
        for (int p = 0; p < 3; p++) begin
            cycle(1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            cycle(1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        for (int p = 0; p < 2; p++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1);
            cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1);
        end
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("cnt_1_three", {16'd0, pkt_cnt_1}, 32'd3);
        check("cnt_2_two", {16'd0, pkt_cnt_2}, 32'd2);
        do_reset();
        for (int p = 0; p < 65537; p++) cycle(1'b0, 1'b1, 8'(p), 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("cnt_1_wrap", {16'd0, pkt_cnt_1}, 32'd1);
`endif

        // Drain with a bounded number of cycles; leftovers mean lost beats
        repeat (6) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("drain_empty", exp_q.size(), 32'd0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
